// File: rtl/hermes_local_inject_arbiter.sv
// ---------------------------------------------------------------------------
// hermes_local_inject_arbiter
//
// Shares one HermesNoC router local input port among NUM_REQ injectors.
// Round-robin arbitration at packet granularity: once a requester is granted
// it owns the port from its header flit through its last payload flit, so
// packets never interleave. Flits pass through combinationally (no added
// pipeline stage); the only overhead is one arbitration cycle per packet.
//
// Packet format: header flit, size flit S, then S payload flits.
//
// Ports
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   req_rx_i      per-requester flit valid
//   req_data_i    per-requester flit (unpacked array)
//   req_credit_o  per-requester flit accept (only the owner ever sees one)
//   rx_o          flit valid to router local port
//   data_o        flit to router local port
//   credit_i      router local credit (space available)
//   grant_o       one-hot current owner, 0 when idle
//   busy_o        a packet is currently owned
//
// States
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | no owner; pick next requester at/after rr_ptr (bubble cycle)
//   S_HEADER  | owner granted, waiting for header flit transfer
//   S_SIZE    | waiting for size flit transfer; loads payload count
//   S_PAYLOAD | forwarding payload flits until the count reaches zero
// ---------------------------------------------------------------------------
module hermes_local_inject_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FLIT_WIDTH = 32,
    parameter int SIZE_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_rx_i,
    input  logic [FLIT_WIDTH-1:0] req_data_i [NUM_REQ],
    output logic [NUM_REQ-1:0]    req_credit_o,
    output logic                  rx_o,
    output logic [FLIT_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic                  busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_SIZE    = 2'd2,
        S_PAYLOAD = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      next_ptr;
    logic                  xfer;

    // Round-robin pick: scan offsets from the highest down so the requester
    // closest to rr_ptr (smallest offset) is the last one written and wins.
    // One extra bit keeps rr_ptr+offset from overflowing before the wrap.
    always_comb begin
        logic [IDX_W:0]   cand;
        logic [IDX_W-1:0] cand_idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            cand_idx = cand[IDX_W-1:0];
            if (req_rx_i[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign next_ptr = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                           : grant_idx_q + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        rr_ptr_d     = rr_ptr_q;
        remaining_d  = remaining_q;
        rx_o         = 1'b0;
        data_o       = '0;
        req_credit_o = '0;
        grant_o      = '0;
        busy_o       = 1'b0;
        xfer         = 1'b0;

        if (state_q != S_IDLE) begin
            rx_o                      = req_rx_i[grant_idx_q];
            data_o                    = req_data_i[grant_idx_q];
            req_credit_o[grant_idx_q] = credit_i;
            grant_o[grant_idx_q]      = 1'b1;
            busy_o                    = 1'b1;
            xfer                      = req_rx_i[grant_idx_q] & credit_i;
        end

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_idx_d = pick_idx;
                    state_d     = S_HEADER;
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    state_d = S_SIZE;
                end
            end
            S_SIZE: begin
                if (xfer) begin
                    // Only the low SIZE_WIDTH bits count; upper bits just pass through.
                    remaining_d = data_o[SIZE_WIDTH-1:0];
                    if (data_o[SIZE_WIDTH-1:0] == '0) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = next_ptr;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    remaining_d = remaining_q - SIZE_WIDTH'(1);
                    if (remaining_q == SIZE_WIDTH'(1)) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
        end
    end

endmodule
